// File: rtl/feeder_pkg.sv
// Shared types and defaults for the ptos_word_feeder serialiser.
// FEEDER_PARITY_EN (in the top) enables the trailing even-parity cycle.
package feeder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } feeder_state_t;

    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ptos_word_feeder_bit_down_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module bit_down_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ptos_word_feeder.sv
// Parallel-to-serial word feeder, MSB first, back-to-back streaming.
// Define FEEDER_PARITY_EN to append an even-parity bit after each word.
module ptos_word_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    feeder_state_t    state_r;
    feeder_state_t    next_state_s;
    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] bit_cnt_s;
    logic             cnt_zero_s;
    logic             cnt_dec_s;
    logic             accept_s;
`ifdef FEEDER_PARITY_EN
    logic             parity_r;
`endif

    // load_ready never looks at load_valid, so this has no combinational loop.
    assign accept_s  = load_valid && load_ready;
    assign cnt_dec_s = (state_r == SHIFT) && (bit_cnt_s != {CNT_W{1'b0}});

    bit_down_counter #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept_s),
        .load_value (LAST_CNT),
        .dec        (cnt_dec_s),
        .count      (bit_cnt_s),
        .zero       (cnt_zero_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode; outputs depend only on state and count.
    always_comb begin
        next_state_s = state_r;
        load_ready   = 1'b0;
        word_done    = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        case (state_r)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                serial_out   = shift_r[WIDTH-1];
                serial_valid = 1'b1;
                if (cnt_zero_s) begin
`ifdef FEEDER_PARITY_EN
                    next_state_s = PARITY;
`else
                    load_ready = 1'b1;
                    word_done  = 1'b1;
                    if (load_valid) begin
                        next_state_s = SHIFT;
                    end else begin
                        next_state_s = IDLE;
                    end
`endif
                end else begin
                    next_state_s = SHIFT;
                end
            end
`ifdef FEEDER_PARITY_EN
            PARITY: begin
                serial_out   = parity_r;
                serial_valid = 1'b1;
                load_ready   = 1'b1;
                word_done    = 1'b1;
                if (load_valid) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
`endif
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shift register: reload on accept, zero-filled left shift while serialising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            shift_r <= load_data;
        end else if (state_r == SHIFT) begin
            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
        end else begin
            shift_r <= shift_r;
        end
    end

`ifdef FEEDER_PARITY_EN
    // Parity is captured at accept since the data is only valid in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (accept_s) begin
            parity_r <= even_parity(64'(load_data));
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

endmodule

// File: tb/tb_ptos_word_feeder.sv
// Self-checking bench for ptos_word_feeder against a queue-of-bits stream model.
// Honours FEEDER_PARITY_EN the same way as the design.
module tb_ptos_word_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         word_done;

    int checks = 0;
    int errors = 0;

    // Reference: the bits still to be sent, in wire order.
    bit       exp_q[$];
    logic [3:0] exp_vec;
    wire  [3:0] obs = {serial_out, serial_valid, word_done, load_ready};

    ptos_word_feeder #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .word_done    (word_done)
    );

    always #5 clk = ~clk;

    // Drive one cycle; compute the expectation for this cycle into exp_vec,
    // then advance the model past the coming rising edge.
    task automatic drive(input logic v, input logic [W-1:0] d, output logic acc);
        int   n;
        logic rdy;
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        #1;
        n   = exp_q.size();
        rdy = (n <= 1);
        exp_vec = {(n > 0) ? logic'(exp_q[0]) : 1'b0, (n > 0), (n == 1), rdy};
        acc = v && rdy;
        if (n > 0) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef FEEDER_PARITY_EN
            exp_q.push_back(^d);
`endif
        end
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1;
        load_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", obs, 4'b0001);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, W'($urandom), acc);
            checks++;
            if (obs !== 4'b0001 || obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b want %b", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_single_word();
        logic acc;
        logic [7:0] pattern = 8'b1101_0000;
        for (int k = 0; k <= W + 2; k++) begin
            drive(k == 0, (k == 0) ? 8'hD0 : W'($urandom), acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL single_word cyc T+%0d got %b want %b", k, obs, exp_vec);
            end
            if (k >= 1 && k <= W) begin
                checks++;
                if (serial_out !== pattern[W - k]) begin
                    errors++;
                    $display("FAIL single_word_bit T+%0d got %b want %b", k, serial_out, pattern[W - k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [W-1:0] words [2] = '{8'hFF, 8'h00};
        int idx = 0;
        int ready_cnt = 0;
        for (int k = 0; k < 2 * W + 4; k++) begin
            drive(idx < 2, (idx < 2) ? words[idx] : W'($urandom), acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %b want %b", k, obs, exp_vec);
            end
            if (load_ready && k <= W * 2) ready_cnt++;
            if (acc) idx++;
        end
        checks++;
`ifdef FEEDER_PARITY_EN
        if (idx !== 2) begin
`else
        if (idx !== 2 || ready_cnt !== 3) begin
`endif
            errors++;
            $display("FAIL back_to_back_accepts got %0d/%0d want 2/3", idx, ready_cnt);
        end
    endtask

    task automatic test_ignored_load();
        logic acc;
        for (int k = 0; k <= W + 2; k++) begin
            drive(k == 0 || k == 3, (k == 0) ? 8'h3C : 8'hAA, acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL ignored_load cyc T+%0d got %b want %b", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic acc;
        for (int k = 0; k <= 4; k++) begin
            drive(k == 0, 8'hB4, acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_reset_pre cyc T+%0d got %b want %b", k, obs, exp_vec);
            end
        end
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_async got %b want %b", obs, 4'b0001);
        end
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k <= W + 2; k++) begin
            drive(k == 0, 8'hB4, acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_reset_fresh cyc T+%0d got %b want %b", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_random_stream();
        logic acc;
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, W'($urandom), acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_stream cyc %0d got %b want %b", k, obs, exp_vec);
            end
        end
        for (int k = 0; k < W + 3; k++) begin
            drive(1'b0, W'($urandom), acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_drain cyc %0d got %b want %b", k, obs, exp_vec);
            end
        end
    endtask

`ifdef FEEDER_PARITY_EN
    task automatic test_parity();
        logic acc;
        for (int k = 0; k <= W + 1; k++) begin
            drive(k == 0 || k == W + 1, (k == 0) ? 8'hD0 : 8'h01, acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL parity cyc T+%0d got %b want %b", k, obs, exp_vec);
            end
            if (k == W + 1) begin
                checks++;
                if (obs !== 4'b1111 || acc !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_bit got %b acc %b want 1111 acc 1", obs, acc);
                end
            end
        end
        for (int k = 0; k < W + 3; k++) begin
            drive(1'b0, 8'h00, acc);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL parity_drain cyc %0d got %b want %b", k, obs, exp_vec);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_word();
`ifdef FEEDER_PARITY_EN
        test_parity();
`endif
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
